// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for serial_subtractor
// Optional overflow signal present when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             borrow_in;
    logic [WIDTH-1:0] diff;
    logic             outborrow;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start, minuend, subtrahend, borrow_in,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        input  overflow,
`endif
        input  diff, outborrow, busy, done
    );

    modport slave (
        input  start, minuend, subtrahend, borrow_in,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        output overflow,
`endif
        output diff, outborrow, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell
// Optional two's-complement overflow flag enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, s_q, diff_q;
    logic               b_q, outborrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept, last_bit, d_bit, b_next;

    assign accept   = (state_q != RUN) && bus.start;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Full-subtractor cell fed from the bottom of the operand shift registers
    assign d_bit  = m_q[0] ^ s_q[0] ^ b_q;
    assign b_next = (~m_q[0] & s_q[0]) | (~(m_q[0] ^ s_q[0]) & b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = last_bit ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic m_msb_q, s_msb_q, overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_msb_q    <= 1'b0;
            s_msb_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            m_msb_q <= bus.minuend[WIDTH-1];
            s_msb_q <= bus.subtrahend[WIDTH-1];
        end else if (state_q == RUN && last_bit) begin
            // The last bit computed is the result MSB
            overflow_q <= (m_msb_q != s_msb_q) && (d_bit != m_msb_q);
        end
    end

    assign bus.overflow = overflow_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q         <= '0;
            s_q         <= '0;
            b_q         <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            outborrow_q <= 1'b0;
        end else if (accept) begin
            m_q   <= bus.minuend;
            s_q   <= bus.subtrahend;
            b_q   <= bus.borrow_in;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            diff_q <= {d_bit, diff_q[WIDTH-1:1]};
            m_q    <= {1'b0, m_q[WIDTH-1:1]};
            s_q    <= {1'b0, s_q[WIDTH-1:1]};
            b_q    <= b_next;
            cnt_q  <= cnt_q + 1'b1;
            if (last_bit) outborrow_q <= b_next;
        end
    end

    assign bus.diff      = diff_q;
    assign bus.outborrow = outborrow_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor (WIDTH=8)
// Overflow checks compiled in when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         ob;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [W-1:0] m, input logic [W-1:0] s, input logic bi);
        exp_t        e;
        logic [W:0]  r;
        r    = {1'b0, m} - {1'b0, s} - {{W{1'b0}}, bi};
        e.d  = r[W-1:0];
        e.ob = r[W];
        e.ov = (m[W-1] != s[W-1]) && (r[W-1] != m[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_diff"}, 32'(bus.diff), 32'(e.d));
            chk({tag, "_outborrow"}, 32'(bus.outborrow), 32'(e.ob));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            chk({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ov));
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] s,
                          input logic bi, input bit poke);
        int lat;
        @(negedge clk);
        bus.minuend    = m;
        bus.subtrahend = s;
        bus.borrow_in  = bi;
        bus.start      = 1'b1;
        sb.push_back(model(m, s, bi));
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        if (poke) begin
            // A start request during RUN must neither disturb nor queue
            bus.minuend    = ~m;
            bus.subtrahend = ~s;
            bus.borrow_in  = ~bi;
            bus.start      = 1'b1;
            @(negedge clk); lat++;
            @(negedge clk); lat++;
            bus.start = 1'b0;
        end
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        check_result(tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int  gap;
        int  lat;
        bit  saw_done;

        bus.start      = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;
        bus.borrow_in  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_outborrow", 32'(bus.outborrow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;

        // Reset asserted after three bits of a running operation
        @(negedge clk);
        bus.minuend    = 8'hAA;
        bus.subtrahend = 8'h55;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_outborrow", 32'(bus.outborrow), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst_no_done", 32'(saw_done), 32'd0);

        run_op("op_35_12", 8'h35, 8'h12, 1'b0, 1'b0);
        run_op("op_12_35", 8'h12, 8'h35, 1'b0, 1'b0);
        run_op("op_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op("op_00_00_b", 8'h00, 8'h00, 1'b1, 1'b1);

        // Back-to-back: start held high across the DONE cycle
        @(negedge clk);
        bus.minuend    = 8'h10;
        bus.subtrahend = 8'h01;
        bus.borrow_in  = 1'b0;
        bus.start      = 1'b1;
        sb.push_back(model(8'h10, 8'h01, 1'b0));
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        @(negedge clk);
        bus.minuend    = 8'h01;
        bus.subtrahend = 8'h02;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd8);
        check_result("b2b_first");
        @(negedge clk);
        bus.start = 1'b0;
        gap = 1;
        while (bus.done !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", 32'(gap), 32'd9);
        check_result("b2b_second");

        for (int i = 0; i < 4; i++) begin
            run_op("op_rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        run_op("ovf_80_01", 8'h80, 8'h01, 1'b0, 1'b0);
        run_op("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0, 1'b0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
